pad_motion_controller: RTL
==========================

# pad_motion_controller

Parametrised paddle position controller for the pong playfield. It is the successor to the fixed-speed single-player pad logic. It adds configurable geometry, a velocity ramp while a direction is held, exact edge clamping and an optional AI tracking mode that follows a target Y coordinate. One instance sits per paddle between the input logic (keyboard/buttons or ball position) and the pad drawing stage.

## Interface
- Y_W, 10, width of all Y coordinates
- SCREEN_H, 768, visible lines
- PAD_H, 145, pad height in lines
- Y_HOME, 312, pad top after reset or still_graphic
- V_MIN, 1, starting speed in lines/tick
- V_MAX, 6, maximum speed in lines/tick (V_MIN ≤ V_MAX ≤ 15)
- ACC_TICKS, 4, number of moving ticks at one speed before speed+1
- DEAD_ZONE, 8, AI half-window around pad centre
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- timing_tick  in  1  one-cycle motion strobe (frame rate)
- up_in  in  1  manual up request
- down_in  in  1  manual down request
- ai_en  in  1  1 = track target_y, 0 = manual
- target_y  in  Y_W  AI target (typically ball centre Y)
- still_graphic  in  1  freeze/home request (menu, serve)
- y_pad  out  Y_W  pad top line
- speed  out  4  current velocity
- moving  out  1  FSM not in IDLE
- at_top  out  1  y_pad == 0
- at_bottom  out  1  y_pad == Y_MAX

## Operation
- Y_MAX = SCREEN_H − PAD_H (623 at defaults). Y_MIN = 0.
- up_in, down_in, ai_en and target_y are registered one cycle before use.
- Request decode, manual mode: down & ~up → DN. up & ~down → UP. Both or neither → NONE.
- Request decode, AI mode: centre = y_pad + PAD_H/2 (floor). target > centre + DEAD_ZONE → DN. target < centre − DEAD_ZONE → UP. Otherwise NONE. Compute in Y_W+1 bits with no wrap.
- FSM states: IDLE, MOVE_UP, MOVE_DN. Transitions happen only on timing_tick.
  - Request NONE → IDLE.
  - Request differs from the current direction → the new MOVE state, with speed = V_MIN and acc_cnt = 0.
  - Same direction held → stay in the current MOVE state.
- Motion on each tick in a MOVE state (including the entry tick):
  - y_pad ± speed, saturated to [0, Y_MAX]. Arithmetic is Y_W+1 bits signed; no underflow or overflow wrap.
  - acc_cnt increments. When it reaches ACC_TICKS it clears, and speed increments, saturating at V_MAX.
- Clamp: a tick that saturates at a boundary resets speed to V_MIN and acc_cnt to 0. The state stays in MOVE while the request is held, and y_pad holds.
- IDLE: speed = V_MIN, acc_cnt = 0.
- still_graphic has priority over everything and does not need a tick. On the next edge: y_pad = Y_HOME, IDLE, speed = V_MIN, acc_cnt = 0. These are held while still_graphic is asserted.
- rst: identical effect to still_graphic.

## Timing
- Reset values: y_pad = Y_HOME, speed = V_MIN, moving = 0, at_top = (Y_HOME == 0), at_bottom = (Y_HOME == Y_MAX). All are 0 at defaults.
- Latency: a request present at edge n is registered. If timing_tick = 1 in cycle n+1, then y_pad, speed and state update at edge n+2.
- A request held only between ticks has no effect.
- at_top, at_bottom and moving are registered. They reflect the updated y_pad and state in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Switching ai_en mid-motion: the next tick decodes in the new mode. A direction change resets speed per the FSM rules.

## Test plan
- **Reset:** pulse rst → y_pad = 312, speed = 1, moving = 0, at_top = at_bottom = 0.
- **Ramp:** hold down_in for 8 ticks from 312 → y_pad sequence 313, 314, 315, 316, 318, 320, 322, 324. speed = 3 after the 8th tick.
- **Top clamp:** start at y_pad = 5, speed 1, hold up → 4, 3, 2, 1, 0, then 0 remains. at_top = 1, speed = 1, moving = 1. Repeat at the bottom with a start of 621 at speed 2 → 623, at_bottom = 1, no wrap.
- **Reversal/conflict:** moving down at speed 3, switch to up → next tick y_pad −1 and speed = 1. Assert up and down together → IDLE, no motion.
- **AI mode:** ai_en = 1, y_pad = 312 (centre 384):
  - target 500 → pad moves down.
  - target 390 → no motion (inside ±8).
  - target 300 → pad moves up.
- **Freeze:** still_graphic asserted mid-move at y_pad = 400, speed 3, no tick → next edge y_pad = 312, speed = 1, moving = 0. Held ticks with down_in cause no motion.

Source files
------------

// File: rtl/pad_motion_controller.sv
// rtl/pad_motion_controller.sv - paddle position controller with speed ramp, edge clamp and AI tracking
module pad_motion_controller #(
    parameter int Y_W       = 10,
    parameter int SCREEN_H  = 768,
    parameter int PAD_H     = 145,
    parameter int Y_HOME    = 312,
    parameter int V_MIN     = 1,
    parameter int V_MAX     = 6,
    parameter int ACC_TICKS = 4,
    parameter int DEAD_ZONE = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           timing_tick,
    input  logic           up_in,
    input  logic           down_in,
    input  logic           ai_en,
    input  logic [Y_W-1:0] target_y,
    input  logic           still_graphic,
    output logic [Y_W-1:0] y_pad,
    output logic [3:0]     speed,
    output logic           moving,
    output logic           at_top,
    output logic           at_bottom
);

    localparam int AW    = Y_W + 2;
    localparam int ACC_W = $clog2(ACC_TICKS + 1);
    localparam logic [Y_W-1:0]       Y_MAX_U = Y_W'(SCREEN_H - PAD_H);
    localparam logic signed [AW-1:0] Y_MAX_S = AW'(SCREEN_H - PAD_H);
    localparam logic [Y_W-1:0]       Y_HOME_U = Y_W'(Y_HOME);
    localparam logic [3:0]           V_MIN_U = 4'(V_MIN);
    localparam logic [3:0]           V_MAX_U = 4'(V_MAX);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN} state_t;

    state_t           state, state_n, req;
    logic             up_r, down_r, ai_r;
    logic [Y_W-1:0]   target_r;
    logic [ACC_W-1:0] acc_cnt, acc_n, base_acc;
    logic [Y_W-1:0]   y_n;
    logic [3:0]       speed_n, base_speed;
    logic [AW-1:0]    centre, tgt, step;
    logic signed [AW-1:0] pos;

    // Request decode; the requested direction is expressed as the MOVE state it leads to.
    always_comb begin
        req    = IDLE;
        centre = {2'b00, y_pad} + AW'(PAD_H / 2);
        tgt    = {2'b00, target_r};
        if (ai_r) begin
            if (tgt > centre + AW'(DEAD_ZONE))
                req = MOVE_DN;
            else if (tgt + AW'(DEAD_ZONE) < centre)
                req = MOVE_UP;
        end else if (down_r && !up_r) begin
            req = MOVE_DN;
        end else if (up_r && !down_r) begin
            req = MOVE_UP;
        end
    end

    always_comb begin
        state_n    = state;
        y_n        = y_pad;
        speed_n    = speed;
        acc_n      = acc_cnt;
        base_speed = speed;
        base_acc   = acc_cnt;
        step       = '0;
        pos        = '0;
        if (timing_tick) begin
            if (req == IDLE) begin
                state_n = IDLE;
                speed_n = V_MIN_U;
                acc_n   = '0;
            end else begin
                state_n = req;
                if (req != state) begin
                    base_speed = V_MIN_U;
                    base_acc   = '0;
                end
                step = {{(AW-4){1'b0}}, base_speed};
                if (req == MOVE_DN)
                    pos = $signed({2'b00, y_pad}) + $signed(step);
                else
                    pos = $signed({2'b00, y_pad}) - $signed(step);
                // Overshooting an edge parks the pad on it and restarts the ramp.
                if (pos[AW-1]) begin
                    y_n     = '0;
                    speed_n = V_MIN_U;
                    acc_n   = '0;
                end else if (pos > Y_MAX_S) begin
                    y_n     = Y_MAX_U;
                    speed_n = V_MIN_U;
                    acc_n   = '0;
                end else begin
                    y_n = pos[Y_W-1:0];
                    if (base_acc == ACC_W'(ACC_TICKS - 1)) begin
                        acc_n   = '0;
                        speed_n = (base_speed >= V_MAX_U) ? V_MAX_U : base_speed + 4'd1;
                    end else begin
                        acc_n   = base_acc + ACC_W'(1);
                        speed_n = base_speed;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_r     <= 1'b0;
            down_r   <= 1'b0;
            ai_r     <= 1'b0;
            target_r <= '0;
        end else begin
            up_r     <= up_in;
            down_r   <= down_in;
            ai_r     <= ai_en;
            target_r <= target_y;
        end

        if (rst || still_graphic) begin
            state     <= IDLE;
            y_pad     <= Y_HOME_U;
            speed     <= V_MIN_U;
            acc_cnt   <= '0;
            moving    <= 1'b0;
            at_top    <= (Y_HOME_U == '0);
            at_bottom <= (Y_HOME_U == Y_MAX_U);
        end else begin
            state     <= state_n;
            y_pad     <= y_n;
            speed     <= speed_n;
            acc_cnt   <= acc_n;
            moving    <= (state_n != IDLE);
            at_top    <= (y_n == '0);
            at_bottom <= (y_n == Y_MAX_U);
        end
    end

endmodule
